// File: rtl/sdspi_target_pkg.sv
// Shared types for the SD SPI target: byte type, command framer states and CRC7 helper.
package sdspi_target_pkg;

    typedef logic [7:0] sdBYTE_t;

    typedef enum logic [1:0] {CMD_IDLE, CMD_ARG, CMD_CRC} cmdstate_t;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Bitwise CRC7 (x^7+x^3+1), MSB of the data byte first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crcIn, input sdBYTE_t data);
        logic [6:0] c;
        sdBYTE_t    d;
        logic       fb;
        c = crcIn;
        d = data;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[6] ^ d[7];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ CRC7_POLY;
            d  = {d[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sdspi_target_phy.sv
// SPI target physical layer: pin synchronisers, SCLK edge detect, rx/tx shift registers, tx holding register.
module sdspi_target_phy
    import sdspi_target_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter sdBYTE_t     IDLE_BYTE   = 8'hFF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    spi_sclk,
    input  logic    spi_cs,
    input  logic    spi_mosi,
    output logic    spi_miso,
    output sdBYTE_t rx_data,
    output logic    rx_valid,
    input  sdBYTE_t tx_data,
    input  logic    tx_valid,
    output logic    tx_ready,
    output logic    tx_underrun,
    output logic    frameAbort
);

    logic [SYNC_STAGES-1:0] sclkSync, csSync, mosiSync;
    logic    sclkS, csS, mosiS;
    logic    sclkPrev, csPrev;
    logic    rise, fall, byteStart;
    logic [2:0] bitcnt;
    sdBYTE_t rxShift, txShift, holdData, loadByte;
    logic    holdFull, rxUpd;

    assign sclkS = sclkSync[SYNC_STAGES-1];
    assign csS   = csSync[SYNC_STAGES-1];
    assign mosiS = mosiSync[SYNC_STAGES-1];

    assign rise      = !csS && !sclkPrev &&  sclkS;
    assign fall      = !csS &&  sclkPrev && !sclkS;
    assign byteStart = fall && (bitcnt == 3'd0);
    assign loadByte  = holdFull ? holdData : IDLE_BYTE;
    assign tx_ready  = !holdFull;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclkSync    <= '1;
            csSync      <= '1;
            mosiSync    <= '1;
            sclkPrev    <= 1'b1;
            csPrev      <= 1'b1;
            bitcnt      <= '0;
            rxShift     <= '0;
            txShift     <= '1;
            holdData    <= '0;
            holdFull    <= 1'b0;
            spi_miso    <= 1'b1;
            rx_data     <= 8'hFF;
            rxUpd       <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frameAbort  <= 1'b0;
        end else begin
            sclkSync    <= {sclkSync[SYNC_STAGES-2:0], spi_sclk};
            csSync      <= {csSync[SYNC_STAGES-2:0], spi_cs};
            mosiSync    <= {mosiSync[SYNC_STAGES-2:0], spi_mosi};
            sclkPrev    <= sclkS;
            csPrev      <= csS;
            rxUpd       <= 1'b0;
            rx_valid    <= rxUpd;
            tx_underrun <= 1'b0;
            frameAbort  <= 1'b0;

            if (csS) begin
                spi_miso <= 1'b1;
                if (!csPrev) begin
                    bitcnt     <= '0;
                    frameAbort <= 1'b1;
                end
            end else begin
                if (rise) begin
                    rxShift <= {rxShift[6:0], mosiS};
                    bitcnt  <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        rx_data <= {rxShift[6:0], mosiS};
                        rxUpd   <= 1'b1;
                    end
                end
                if (byteStart) begin
                    spi_miso    <= loadByte[7];
                    txShift     <= {loadByte[6:0], 1'b1};
                    tx_underrun <= !holdFull;
                end else if (fall) begin
                    spi_miso <= txShift[7];
                    txShift  <= {txShift[6:0], 1'b1};
                end
            end

            // An accept can only happen while empty, so a coinciding byte start already took IDLE_BYTE.
            if (tx_valid && !holdFull) begin
                holdData <= tx_data;
                holdFull <= 1'b1;
            end else if (byteStart) begin
                holdFull <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdspi_target.sv
// SD card side SPI target: PHY plus 6-byte command framer with CRC7 check.
module sdspi_target
    import sdspi_target_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter sdBYTE_t     IDLE_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output sdBYTE_t     rx_data,
    output logic        rx_valid,
    input  sdBYTE_t     tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_underrun,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_ok
);

    logic        frameAbort;
    cmdstate_t   state;
    logic [2:0]  byteCnt;
    logic [6:0]  crc;
    logic [5:0]  idxReg;
    logic [31:0] argReg;

    sdspi_target_phy #(
        .SYNC_STAGES(SYNC_STAGES),
        .IDLE_BYTE  (IDLE_BYTE)
    ) u_phy (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_underrun(tx_underrun),
        .frameAbort (frameAbort)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CMD_IDLE;
            byteCnt    <= '0;
            crc        <= '0;
            idxReg     <= '0;
            argReg     <= '0;
            cmd_valid  <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
            cmd_crc_ok <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (frameAbort) begin
                state <= CMD_IDLE;
            end else if (rx_valid) begin
                case (state)
                    CMD_IDLE: begin
                        if (rx_data[7:6] == 2'b01) begin
                            state   <= CMD_ARG;
                            byteCnt <= 3'd1;
                            idxReg  <= rx_data[5:0];
                            crc     <= crc7_byte('0, rx_data);
                        end
                    end
                    CMD_ARG: begin
                        argReg  <= {argReg[23:0], rx_data};
                        crc     <= crc7_byte(crc, rx_data);
                        byteCnt <= byteCnt + 3'd1;
                        if (byteCnt == 3'd4) state <= CMD_CRC;
                    end
                    CMD_CRC: begin
                        cmd_valid  <= 1'b1;
                        cmd_index  <= idxReg;
                        cmd_arg    <= argReg;
                        cmd_crc_ok <= (rx_data[7:1] == crc);
                        state      <= CMD_IDLE;
                    end
                    default: state <= CMD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdspi_target.sv
// Scoreboard bench for sdspi_target: mode-3 SPI initiator model with directed SD command frames.
`timescale 1ns/1ps
module tb_sdspi_target;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        ok;
    } cmdExp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b1;
    logic        spi_miso;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx_underrun;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_crc_ok;

    int nCmp = 0;
    int nErr = 0;
    int rxCount = 0;
    int underrunCnt = 0;
    logic [7:0] expRx[$];
    cmdExp_t    expCmd[$];
    logic [7:0] frameBuf[$];
    logic [7:0] rxE;
    cmdExp_t    cmdE;

    sdspi_target #(
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_underrun(tx_underrun),
        .cmd_valid  (cmd_valid),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .cmd_crc_ok (cmd_crc_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a command.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_underrun) underrunCnt++;
            if (rx_valid) begin
                rxCount++;
                if (expRx.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL rx_unexpected: got %h expected none", rx_data);
                end else begin
                    rxE = expRx.pop_front();
                    chk("rx_data", {24'h0, rx_data}, {24'h0, rxE});
                end
            end
            if (cmd_valid) begin
                if (expCmd.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL cmd_unexpected: got idx %0d arg %h", cmd_index, cmd_arg);
                end else begin
                    cmdE = expCmd.pop_front();
                    chk("cmd_index", {26'h0, cmd_index}, {26'h0, cmdE.idx});
                    chk("cmd_arg", cmd_arg, cmdE.arg);
                    chk("cmd_crc_ok", {31'h0, cmd_crc_ok}, {31'h0, cmdE.ok});
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic waitHalf();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic spiBits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic [7:0] sh;
        sh = mo;
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            spi_sclk = 1'b0;
            spi_mosi = sh[7];
            sh = {sh[6:0], 1'b0};
            waitHalf();
            mi = {mi[6:0], spi_miso};
            spi_sclk = 1'b1;
            waitHalf();
        end
    endtask

    task automatic spiByte(input logic [7:0] mo, output logic [7:0] mi);
        expRx.push_back(mo);
        spiBits(mo, 8, mi);
    endtask

    task automatic csAssert();
        spi_cs = 1'b0;
        waitHalf();
    endtask

    task automatic csRelease();
        waitHalf();
        spi_cs = 1'b1;
        repeat (3) waitHalf();
    endtask

    task automatic runFrame();
        logic [7:0] mi;
        csAssert();
        foreach (frameBuf[i]) spiByte(frameBuf[i], mi);
        csRelease();
        frameBuf.delete();
    endtask

    task automatic txPush(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("tx_ready_timeout", 32'd0, 32'd1);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_miso"}, {31'h0, spi_miso}, 32'd1);
        chk({tag, "_rx_data"}, {24'h0, rx_data}, 32'hFF);
        chk({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'd0);
        chk({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'd1);
        chk({tag, "_tx_underrun"}, {31'h0, tx_underrun}, 32'd0);
        chk({tag, "_cmd_valid"}, {31'h0, cmd_valid}, 32'd0);
        chk({tag, "_cmd_index"}, {26'h0, cmd_index}, 32'd0);
        chk({tag, "_cmd_arg"}, cmd_arg, 32'd0);
        chk({tag, "_cmd_crc_ok"}, {31'h0, cmd_crc_ok}, 32'd0);
    endtask

    initial begin
        logic [7:0] mi;
        int uBefore;
        int rBefore;

        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // CMD0
        frameBuf = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        expCmd.push_back('{idx: 6'd0, arg: 32'h0, ok: 1'b1});
        runFrame();

        // MISO bytes from holding register, then underrun
        uBefore = underrunCnt;
        txPush(8'hA5);
        chk("tx_ready_after_load1", {31'h0, tx_ready}, 32'd0);
        csAssert();
        spiByte(8'hFF, mi);
        chk("miso_byte1", {24'h0, mi}, 32'hA5);
        chk("tx_ready_after_byte1", {31'h0, tx_ready}, 32'd1);
        txPush(8'h3C);
        chk("tx_ready_after_load2", {31'h0, tx_ready}, 32'd0);
        spiByte(8'hFF, mi);
        chk("miso_byte2", {24'h0, mi}, 32'h3C);
        chk("tx_ready_after_byte2", {31'h0, tx_ready}, 32'd1);
        spiByte(8'hFF, mi);
        chk("miso_byte3", {24'h0, mi}, 32'hFF);
        csRelease();
        chk("underrun_count", underrunCnt - uBefore, 32'd1);

        // CMD17 with bad CRC
        frameBuf = '{8'h51, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01};
        expCmd.push_back('{idx: 6'd17, arg: 32'h200, ok: 1'b0});
        runFrame();

        // Partial byte discarded on CS deassert
        csAssert();
        spiBits(8'hC3, 4, mi);
        csRelease();
        rBefore = rxCount;
        frameBuf = '{8'h5A};
        runFrame();
        chk("rx_count_after_abort", rxCount - rBefore, 32'd1);

        // Aborted command followed by CMD8
        frameBuf = '{8'h48, 8'h00, 8'h00};
        runFrame();
        frameBuf = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
        expCmd.push_back('{idx: 6'd8, arg: 32'h1AA, ok: 1'b1});
        runFrame();

        // Reset in the middle of a byte inside a command
        csAssert();
        spiByte(8'h40, mi);
        spiByte(8'h00, mi);
        spiBits(8'hFF, 3, mi);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkReset("midreset");
        spi_cs   = 1'b1;
        spi_sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        frameBuf = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65};
        expCmd.push_back('{idx: 6'd55, arg: 32'h0, ok: 1'b1});
        runFrame();

        repeat (10) @(posedge clk);
        #1;
        chk("rx_queue_drained", expRx.size(), 32'd0);
        chk("cmd_queue_drained", expCmd.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
